fanout_bcast8: RTL and testbench

- Eight-port broadcast distributor. One input word (valid/ready) is delivered to eight output ports a..h.
- Each port has its own valid/ready handshake and completes independently (eager fork).
- A new word is accepted only after every port has taken the current one.
- Sits in front of eight-operand consumers: per-port delivery is the sequential counterpart of combining ports a..h into one result.

---
 rtl/fanout_bcast8.sv | 94 +++++++++
 tb/tb_fanout_bcast8.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fanout_bcast8.sv
// fanout_bcast8: eager-fork broadcast of one valid/ready word to eight ports a..h.
// Optional macro FANOUT_BCAST8_PORT_MASK_EN adds a per-word port_mask input.
module fanout_bcast8 #(
    parameter int Port_Num = 2,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef FANOUT_BCAST8_PORT_MASK_EN
    input  logic [7:0]       port_mask,
`endif
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [7:0]       vld,
    input  logic [7:0]       rdy,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [7:0]       pending;
    logic [WIDTH-1:0] hold;

    logic [7:0] remain;
    logic [7:0] load_mask;
    logic       accept;
    logic       complete;
    logic       zero_load;
    logic [1:0] cnt_inc;

    // Port_Num is an interface tag shared with the combine blocks only.
    if (Port_Num < 0) begin : g_port_num_tag
    end

    always_comb begin
        remain   = pending & ~rdy;
        in_ready = (remain == 8'h00);
        accept   = in_valid & in_ready;
`ifdef FANOUT_BCAST8_PORT_MASK_EN
        load_mask = port_mask;
`else
        load_mask = 8'hFF;
`endif
        complete  = (state == HOLD) && (remain == 8'h00);
        // A fully masked word is delivered the moment it is accepted.
        zero_load = accept && (load_mask == 8'h00);
        cnt_inc   = {1'b0, complete} + {1'b0, zero_load};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= 8'h00;
            hold     <= '0;
            word_cnt <= 16'h0000;
        end else begin
            if (accept) begin
                hold    <= in_data;
                pending <= load_mask;
                state   <= (load_mask != 8'h00) ? HOLD : IDLE;
            end else begin
                pending <= remain;
                state   <= (remain != 8'h00) ? HOLD : IDLE;
            end
            word_cnt <= word_cnt + 16'(cnt_inc);
        end
    end

    assign a    = hold;
    assign b    = hold;
    assign c    = hold;
    assign d    = hold;
    assign e    = hold;
    assign f    = hold;
    assign g    = hold;
    assign h    = hold;
    assign vld  = pending;
    assign busy = |pending;

endmodule

// File: tb/tb_fanout_bcast8.sv
// Testbench for fanout_bcast8: per-port delivery model checked every cycle
// plus directed literal expectations.
module tb_fanout_bcast8;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       port_mask;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [7:0]       vld;
    logic [7:0]       rdy;
    logic             busy;
    logic [15:0]      word_cnt;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    fanout_bcast8 #(.Port_Num(2), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef FANOUT_BCAST8_PORT_MASK_EN
        .port_mask(port_mask),
`endif
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .e        (e),
        .f        (f),
        .g        (g),
        .h        (h),
        .vld      (vld),
        .rdy      (rdy),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: which ports still owe a delivery, the word on offer, words delivered.
    bit        m_owe [8];
    logic [7:0] m_word;
    int        m_cnt;

    function automatic bit m_in_ready(input logic [7:0] r);
        for (int i = 0; i < 8; i++)
            if (m_owe[i] && !r[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_vld();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_owe[i];
        return v;
    endfunction

    always @(posedge clk) begin
        bit any_owed;
        bit take;
        logic [7:0] msk;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_owe[i] = 1'b0;
            m_word = 8'h00;
            m_cnt  = 0;
        end else begin
            take = in_valid && m_in_ready(rdy);
            any_owed = 1'b0;
            for (int i = 0; i < 8; i++) any_owed |= m_owe[i];
            if (any_owed && m_in_ready(rdy)) m_cnt = (m_cnt + 1) % 65536;
            for (int i = 0; i < 8; i++)
                if (rdy[i]) m_owe[i] = 1'b0;
            if (take) begin
`ifdef FANOUT_BCAST8_PORT_MASK_EN
                msk = port_mask;
`else
                msk = 8'hFF;
`endif
                for (int i = 0; i < 8; i++) m_owe[i] = msk[i];
                m_word = in_data;
                if (msk == 8'h00) m_cnt = (m_cnt + 1) % 65536;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("mdl_vld", vld, m_vld());
            chk("mdl_busy", busy, |m_vld());
            chk("mdl_in_ready", in_ready, m_in_ready(rdy));
            chk("mdl_cnt", word_cnt, m_cnt[15:0]);
            chk("mdl_a", a, m_word);
            chk("mdl_b", b, m_word);
            chk("mdl_c", c, m_word);
            chk("mdl_d", d, m_word);
            chk("mdl_e", e, m_word);
            chk("mdl_f", f, m_word);
            chk("mdl_g", g, m_word);
            chk("mdl_h", h, m_word);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] stg_rdy [6] = '{8'h01, 8'h00, 8'h7E, 8'h00, 8'h00, 8'h80};
    logic [7:0] stg_vld [6] = '{8'hFE, 8'hFE, 8'h80, 8'h80, 8'h80, 8'h00};
    logic       stg_ir  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        rdy       = 8'hFF;
        port_mask = 8'hFF;

        // Reset held with traffic present
        tick();
        started = 1'b1;
        tick();
        chk("rst_vld", vld, 8'h00);
        chk("rst_a", a, 8'h00);
        chk("rst_h", h, 8'h00);
        chk("rst_cnt", word_cnt, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);

        // Single word, all ready
        in_data  = 8'h5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("one_a", a, 8'h5A);
        chk("one_h", h, 8'h5A);
        chk("one_vld", vld, 8'hFF);
        chk("one_cnt0", word_cnt, 16'd0);
        tick();
        chk("one_vld_done", vld, 8'h00);
        chk("one_cnt1", word_cnt, 16'd1);
        chk("one_a_kept", a, 8'h5A);

        // Staggered port completion
        in_data  = 8'h3C;
        in_valid = 1'b1;
        rdy      = 8'h00;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h99;
        chk("stg_vld0", vld, 8'hFF);
        for (int k = 0; k < 6; k++) begin
            rdy = stg_rdy[k];
            #1;
            chk($sformatf("stg_ir%0d", k + 1), in_ready, stg_ir[k]);
            tick();
            chk($sformatf("stg_vld%0d", k + 1), vld, stg_vld[k]);
            chk($sformatf("stg_a%0d", k + 1), a, 8'h3C);
        end
        chk("stg_cnt", word_cnt, 16'd2);

        // Back-to-back at full rate
        rdy      = 8'hFF;
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 8'(k);
            tick();
            chk($sformatf("b2b_a%0d", k), a, 8'(k));
            chk($sformatf("b2b_vld%0d", k), vld, 8'hFF);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_cnt", word_cnt, 16'd6);
        chk("b2b_vld_end", vld, 8'h00);

        // Reset during delivery
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        rdy      = 8'h00;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("mid_vld_held", vld, 8'hFF);
        chk("mid_a_held", a, 8'hA5);
        rst_n = 1'b0;
        tick();
        chk("mid_vld", vld, 8'h00);
        chk("mid_a", a, 8'h00);
        chk("mid_cnt", word_cnt, 16'd0);
        chk("mid_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Pseudo-random ready/valid mix, checked by the model
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            rdy      = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rdy      = 8'hFF;
        tick();

`ifdef FANOUT_BCAST8_PORT_MASK_EN
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        rdy       = 8'h00;
        port_mask = 8'h81;
        in_data   = 8'hC3;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("msk_vld81", vld, 8'h81);
        rdy = 8'h81;
        tick();
        chk("msk_cnt1", word_cnt, 16'd1);
        port_mask = 8'h00;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("msk0_vld", vld, 8'h00);
        chk("msk0_cnt", word_cnt, 16'd2);
        chk("msk0_ir", in_ready, 1'b1);
        port_mask = 8'hFF;
`endif

        // Counter wrap: 65536 accepts at full rate
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        rdy      = 8'hFF;
        in_valid = 1'b1;
        for (int k = 0; k < 65536; k++) begin
            in_data = 8'(k);
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_ffff", word_cnt, 16'hFFFF);
        tick();
        chk("wrap_zero", word_cnt, 16'h0000);
        chk("wrap_vld", vld, 8'h00);

        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
